// File: rtl/game_controller_pkg.sv
// game_controller_pkg: shared state encodings, bird Y width and BCD helper.
// Revision 1.0
`default_nettype none

package game_controller_pkg;

  localparam int unsigned Y_W              = 11;
  localparam int          GROUND_Y_DEFAULT = 20;
  localparam logic [15:0] BCD_MAX          = 16'h9999;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_PLAY  = 3'd2,
    ST_DYING = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  // Four-digit BCD increment with ripple carry; holds at 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != BCD_MAX) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (v[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/game_controller_bcd_counter.sv
// game_controller_bcd_counter: 4-digit BCD counter with clear, enable, 9999 saturation.
// Revision 1.0
`default_nettype none

module game_controller_bcd_counter
  import game_controller_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        en_i,
  output logic [15:0] count_o
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 16'h0000;
    end else if (en_i) begin
      count_d = bcd_inc(count_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 16'h0000;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/game_controller.sv
// game_controller: flappy-bird game sequencer (state machine, countdown, score, high score).
// Revision 1.0
`default_nettype none

module game_controller
  import game_controller_pkg::*;
#(
  parameter int unsigned PHASE_TICKS = 60,
  parameter int unsigned DEATH_TICKS = 90,
  parameter int          GROUND_Y    = GROUND_Y_DEFAULT
) (
  input  logic                  gameClk,
  input  logic                  resetN,
  input  logic                  button,
  input  logic                  collision,
  input  logic                  pipePassed,
  input  logic signed [Y_W-1:0] birdY,
  output logic                  birdReset,
  output logic                  finished,
  output logic [2:0]            state,
  output logic [1:0]            cdDigit,
  output logic [15:0]           score,
  output logic [15:0]           highScore,
  output logic                  newHigh
);

  localparam logic [15:0]           PHASE_RELOAD = 16'(PHASE_TICKS - 1);
  localparam logic [15:0]           DEATH_RELOAD = 16'(DEATH_TICKS - 1);
  localparam logic signed [Y_W-1:0] GROUND_LIM   = Y_W'(GROUND_Y);

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [1:0]  cd_q, cd_d;
  logic [15:0] high_q, high_d;
  logic        new_high_q, new_high_d;
  logic        button_q;
  logic        score_clr;
  logic        score_en;
  logic        button_rise;
  logic        death;

  // button_q resets high so a button held through reset is not seen as a press.
  assign button_rise = button & ~button_q;
  assign death       = collision | (birdY <= GROUND_LIM);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    cd_d       = cd_q;
    high_d     = high_q;
    new_high_d = new_high_q;
    score_clr  = 1'b0;
    score_en   = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (button_rise) begin
          state_d    = ST_READY;
          timer_d    = PHASE_RELOAD;
          cd_d       = 2'd3;
          score_clr  = 1'b1;
          new_high_d = 1'b0;
        end
      end
      ST_READY: begin
        if (timer_q == 16'd0) begin
          if (cd_q > 2'd1) begin
            cd_d    = cd_q - 2'd1;
            timer_d = PHASE_RELOAD;
          end else begin
            state_d = ST_PLAY;
            cd_d    = 2'd0;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_PLAY: begin
        if (death) begin
          state_d = ST_DYING;
          timer_d = DEATH_RELOAD;
          if (score > high_q) begin
            high_d     = score;
            new_high_d = 1'b1;
          end
        end else begin
          score_en = pipePassed;
        end
      end
      ST_DYING: begin
        if (timer_q == 16'd0) begin
          state_d = ST_OVER;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge gameClk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= ST_IDLE;
      timer_q    <= 16'd0;
      cd_q       <= 2'd0;
      high_q     <= 16'h0000;
      new_high_q <= 1'b0;
      button_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cd_q       <= cd_d;
      high_q     <= high_d;
      new_high_q <= new_high_d;
      button_q   <= button;
    end
  end

  game_controller_bcd_counter u_score (
    .clk_i   (gameClk),
    .rst_ni  (resetN),
    .clear_i (score_clr),
    .en_i    (score_en),
    .count_o (score)
  );

  assign birdReset = (state_q == ST_IDLE) || (state_q == ST_READY);
  assign finished  = (state_q != ST_PLAY);
  assign state     = state_q;
  assign cdDigit   = cd_q;
  assign highScore = high_q;
  assign newHigh   = new_high_q;

endmodule

`default_nettype wire

// File: tb/tb_game_controller.sv
// tb_game_controller: directed table, corner sequences and random stimulus against a reference model.
`default_nettype none

module tb_game_controller;

  localparam int P_TICKS = 4;
  localparam int D_TICKS = 5;

  logic               gameClk = 1'b0;
  logic               resetN;
  logic               button;
  logic               collision;
  logic               pipePassed;
  logic signed [10:0] birdY;
  logic               birdReset;
  logic               finished;
  logic [2:0]         state;
  logic [1:0]         cdDigit;
  logic [15:0]        score;
  logic [15:0]        highScore;
  logic               newHigh;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase number, elapsed cycles in phase, decimal scores.
  int m_st, m_ticks, m_score, m_high;
  bit m_newhigh, m_prev;

  typedef struct {
    logic               btn;
    logic               col;
    logic               pp;
    logic signed [10:0] y;
    logic [2:0]         st;
    logic [1:0]         cd;
  } vec_t;

  vec_t       tbl[16];
  logic [1:0] cd_seq[12];

  game_controller #(
    .PHASE_TICKS (P_TICKS),
    .DEATH_TICKS (D_TICKS),
    .GROUND_Y    (20)
  ) dut (
    .gameClk    (gameClk),
    .resetN     (resetN),
    .button     (button),
    .collision  (collision),
    .pipePassed (pipePassed),
    .birdY      (birdY),
    .birdReset  (birdReset),
    .finished   (finished),
    .state      (state),
    .cdDigit    (cdDigit),
    .score      (score),
    .highScore  (highScore),
    .newHigh    (newHigh)
  );

  always #5 gameClk = ~gameClk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_ticks = 0; m_score = 0; m_high = 0; m_newhigh = 0; m_prev = 1;
  endtask

  task automatic model_step();
    bit rise;
    rise   = button && !m_prev;
    m_prev = button;
    case (m_st)
      0, 4: if (rise) begin m_st = 1; m_ticks = 0; m_score = 0; m_newhigh = 0; end
      1: begin
        m_ticks++;
        if (m_ticks == 3 * P_TICKS) m_st = 2;
      end
      2: begin
        if (collision || birdY <= 20) begin
          m_st = 3; m_ticks = 0;
          if (m_score > m_high) begin m_high = m_score; m_newhigh = 1; end
        end else if (pipePassed && m_score < 9999) begin
          m_score++;
        end
      end
      3: begin
        m_ticks++;
        if (m_ticks == D_TICKS) m_st = 4;
      end
      default: m_st = 0;
    endcase
  endtask

  task automatic check_all();
    chk("state", state, m_st);
    chk("cdDigit", cdDigit, (m_st == 1) ? 3 - m_ticks / P_TICKS : 0);
    chk("score", score, to_bcd(m_score));
    chk("highScore", highScore, to_bcd(m_high));
    chk("newHigh", newHigh, m_newhigh);
    chk("birdReset", birdReset, (m_st == 0 || m_st == 1));
    chk("finished", finished, (m_st != 2));
  endtask

  task automatic cycle();
    model_step();
    @(posedge gameClk);
    #1;
    check_all();
  endtask

  task automatic start_game();
    button = 1'b0;
    cycle();
    button = 1'b1;
    cycle();
    chk("start_ready", state, 3'd1);
    button = 1'b0;
    repeat (3 * P_TICKS) cycle();
    chk("start_play", state, 3'd2);
  endtask

  initial begin
    cd_seq = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1};
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 11'sd100, 3'd0, 2'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 11'sd100, 3'd0, 2'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 11'sd100, 3'd0, 2'd0};
    for (int i = 3; i < 15; i++) begin
      tbl[i] = '{logic'(i % 2), 1'b0, 1'b0, 11'sd100, 3'd1, cd_seq[i-3]};
    end
    tbl[15] = '{1'b0, 1'b0, 1'b0, 11'sd100, 3'd2, 2'd0};

    resetN = 1'b0; button = 1'b1; collision = 1'b0; pipePassed = 1'b0; birdY = 11'sd100;
    model_reset();
    #12;
    check_all();
    resetN = 1'b1;

    // Button held through reset release, then countdown with button chatter.
    for (int i = 0; i < 16; i++) begin
      button = tbl[i].btn; collision = tbl[i].col; pipePassed = tbl[i].pp; birdY = tbl[i].y;
      cycle();
      chk("tbl_state", state, tbl[i].st);
      chk("tbl_cd", cdDigit, tbl[i].cd);
    end
    chk("play_birdReset", birdReset, 1'b0);
    chk("play_finished", finished, 1'b0);

    // Score 5, then pipePassed and collision together: death wins.
    button = 1'b0;
    pipePassed = 1'b1;
    repeat (5) cycle();
    collision = 1'b1;
    cycle();
    collision = 1'b0; pipePassed = 1'b0;
    chk("tie_score", score, 16'h0005);
    chk("tie_state", state, 3'd3);
    chk("tie_high", highScore, 16'h0005);
    chk("tie_newHigh", newHigh, 1'b1);
    chk("tie_finished", finished, 1'b1);
    repeat (D_TICKS - 1) cycle();
    chk("dying_len", state, 3'd3);
    cycle();
    chk("over", state, 3'd4);

    // Ground boundary; lower score keeps the old high score.
    start_game();
    pipePassed = 1'b1;
    repeat (3) cycle();
    pipePassed = 1'b0;
    birdY = 11'sd21;
    repeat (3) cycle();
    chk("y21_play", state, 3'd2);
    birdY = 11'sd20;
    cycle();
    birdY = 11'sd100;
    chk("y20_dying", state, 3'd3);
    chk("g2_high", highScore, 16'h0005);
    chk("g2_newHigh", newHigh, 1'b0);
    repeat (D_TICKS) cycle();

    // BCD carries and saturation.
    start_game();
    pipePassed = 1'b1;
    repeat (12) cycle();
    chk("score12", score, 16'h0012);
    repeat (9998 - 12) cycle();
    chk("score9998", score, 16'h9998);
    repeat (3) cycle();
    chk("score_sat", score, 16'h9999);
    pipePassed = 1'b0;
    collision = 1'b1;
    cycle();
    collision = 1'b0;
    chk("g3_high", highScore, 16'h9999);
    repeat (2) cycle();

    // Asynchronous reset mid-DYING, no clock edge in between.
    #2;
    resetN = 1'b0;
    #1;
    model_reset();
    chk("ar_state", state, 3'd0);
    chk("ar_score", score, 16'h0000);
    chk("ar_high", highScore, 16'h0000);
    chk("ar_birdReset", birdReset, 1'b1);
    chk("ar_finished", finished, 1'b1);
    check_all();
    #3;
    resetN = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      int y;
      button     = ($urandom % 8) == 0;
      collision  = ($urandom % 60) == 0;
      pipePassed = ($urandom % 3) == 0;
      if (($urandom % 25) == 0) y = int'($urandom_range(0, 70)) - 50;
      else                      y = int'($urandom_range(21, 400));
      birdY = y[10:0];
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
